uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 SHALL have port clock  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line; idle high; LSB first; 1 start bit, 1 stop bit, no parity.
REQ-005 SHALL have port baud_tick  input  1  one-cycle pulse from the baud generator, nominally mid-bit once re-phased.
REQ-006 SHALL have port baud_start  output  1  one-cycle pulse re-phasing the baud generator to half a bit period.
REQ-007 SHALL have port data  output  DATA_BITS  last received byte.
REQ-008 SHALL have port data_valid  output  1  data holds an unconsumed byte.
REQ-009 SHALL have port data_ready  input  1  consumer accepts data when data_valid && data_ready.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse: completed byte dropped because data_valid was still high.

Function
REQ-012 SHALL pass rx through a two-flop synchronizer (rx_s) plus one history flop (rx_q); falling edge = rx_q==1 && rx_s==0.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: on falling edge, SHALL assert baud_start for exactly that one cycle and go to START; baud_tick ignored in IDLE.
REQ-015 START: on baud_tick, rx_s==0 -> DATA with bit count 0; rx_s==1 -> IDLE (false start, no flag).
REQ-016 DATA: on each baud_tick SHALL shift rx_s into shift register MSB, shifting right (LSB-first assembly); after the DATA_BITS-th sample -> STOP.
REQ-017 STOP: on baud_tick, rx_s==1 -> byte complete, IDLE; rx_s==0 -> frame_err pulse next cycle, byte discarded, WAIT_HIGH.
REQ-018 WAIT_HIGH: SHALL remain until rx_s==1, then IDLE; no baud_start while line held low (break).
REQ-019 On byte complete with data_valid==0, or data_valid&&data_ready in the same cycle: data loaded, data_valid=1 on the next cycle (latency 1 clock after the stop-bit baud_tick).
REQ-020 On byte complete with data_valid&&!data_ready: data unchanged, overrun pulses next cycle.
REQ-021 data_valid SHALL clear the cycle after data_valid&&data_ready when no byte completes simultaneously.
REQ-022 data SHALL remain stable while data_valid==1 and not accepted.
REQ-023 Bit counter SHALL be $clog2(DATA_BITS+1) bits wide; no wrap beyond DATA_BITS.
REQ-024 baud_tick in the same cycle as a falling edge in IDLE SHALL be ignored.

Reset
REQ-025 Reset SHALL asynchronously force state IDLE, sync/history flops to 1, shift register, bit count and data to 0, and baud_start, data_valid, frame_err, overrun to 0.
REQ-026 Reset mid-frame SHALL abandon the frame with no output pulses; reception restarts only on a new falling edge after reset release.

Structure
REQ-027 State encoding and DATA_BITS default SHALL live in shared package uart_pkg, reused by the transmit controller.
REQ-028 The synchronizer SHALL be sub-module bit_sync (2-flop, reset value parameterised, here 1); everything else in uart_rx_ctrl.

Verification
REQ-029 Baud model: tick every 16 clocks, first tick 8 clocks after baud_start; send 0xA5, ready=1 -> one baud_start, data=0xA5, data_valid one cycle, no flags.
REQ-030 2-clock low glitch on rx -> baud_start once, START returns to IDLE, no data_valid, no frame_err.
REQ-031 Send 0x3C with stop bit low, then rx high -> frame_err one pulse, data_valid stays 0, next frame 0x81 received correctly.
REQ-032 ready=0, send 0x11 then 0x22 -> data=0x11 held, overrun one pulse; raise ready -> 0x11 accepted, data_valid clears.
REQ-033 ready asserted exactly on the cycle 0x44 completes while 0x33 pending -> 0x33 consumed, data=0x44, data_valid stays 1, no overrun.
REQ-034 Reset asserted during DATA bit 4 of a frame -> all outputs 0 immediately, no pulses after release; next full frame 0x5A received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: controller state encoding and default frame width,
// used by both the receive and transmit controllers.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } uart_state_e;

   // Bit counter width able to hold 0..bits without wrapping.
   function automatic int uart_cnt_width(input int bits);
      return $clog2(bits + 1);
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit; reset value is selectable
// so an idle-high line does not look like an edge coming out of reset.
module bit_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start-edge detection, baud re-phasing, LSB-first
// assembly and a one-deep output register with frame-error and overrun pulses.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_BITS = UART_DATA_BITS
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 baud_tick,
   output logic                 baud_start,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int CNT_W = uart_cnt_width(DATA_BITS);

   logic                 rx_s;
   logic                 rx_q;
   logic                 fall;
   uart_state_e          state;
   uart_state_e          state_nxt;
   logic [CNT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 last_bit;
   logic                 shift_en;
   logic                 cnt_clr;
   logic                 byte_done;
   logic                 stop_bad;
   logic                 accept;

   bit_sync #(.RST_VAL(1'b1)) u_rx_sync (
      .clock (clock),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) rx_q <= 1'b1;
      else       rx_q <= rx_s;
   end

   assign fall     = rx_q & ~rx_s;
   assign last_bit = (bit_cnt == CNT_W'(DATA_BITS - 1));
   assign accept   = data_valid & data_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      baud_start = 1'b0;
      shift_en   = 1'b0;
      cnt_clr    = 1'b0;
      byte_done  = 1'b0;
      stop_bad   = 1'b0;
      case (state)
         // Ticks in IDLE belong to the previous frame's phase and are ignored.
         IDLE: if (fall) begin
            baud_start = 1'b1;
            state_nxt  = START;
         end
         START: if (baud_tick) begin
            cnt_clr   = 1'b1;
            state_nxt = rx_s ? IDLE : DATA;
         end
         DATA: if (baud_tick) begin
            shift_en = 1'b1;
            if (last_bit) state_nxt = STOP;
         end
         STOP: if (baud_tick) begin
            if (rx_s) begin
               byte_done = 1'b1;
               state_nxt = IDLE;
            end else begin
               stop_bad  = 1'b1;
               state_nxt = WAIT_HIGH;
            end
         end
         // A held-low line (break) must not retrigger reception.
         WAIT_HIGH: if (rx_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else begin
         if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
         if (cnt_clr)       bit_cnt <= '0;
         else if (shift_en) bit_cnt <= bit_cnt + CNT_W'(1);
      end
   end

   // Output register: a completing byte may replace one being consumed this cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data       <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         overrun   <= 1'b0;
         if (byte_done && (!data_valid || data_ready)) begin
            data       <= shreg;
            data_valid <= 1'b1;
         end else if (byte_done) begin
            overrun <= 1'b1;
         end else if (accept) begin
            data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a frame-timing model of the receiver
// checked against the DUT every cycle, plus literal per-scenario expectations.
module tb_uart_rx_ctrl;

   localparam int N        = 8;
   localparam int BIT_T    = 16;
   localparam int FRAME_T  = BIT_T * (N + 2);
   localparam int STOP_CYC = 10 + BIT_T * (N + 1);

   logic         clock = 1'b0;
   logic         reset;
   logic         rx;
   logic         baud_tick;
   logic         data_ready;
   logic         baud_start;
   logic [N-1:0] data;
   logic         data_valid;
   logic         frame_err;
   logic         overrun;

   always #5 clock = ~clock;

   uart_rx_ctrl #(.DATA_BITS(N)) dut (
      .clock      (clock),
      .reset      (reset),
      .rx         (rx),
      .baud_tick  (baud_tick),
      .baud_start (baud_start),
      .data       (data),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: mode 0 idle, 1 in frame (m_t = cycles since baud_start), 2 waiting for line high.
   int           m_mode;
   int           m_t;
   logic         l1, ls, lq;
   logic [N-1:0] m_byte, m_data;
   logic         m_valid, m_ferr, m_over;
   logic         p_rx, p_rdy, p_rst;
   int           btimer;

   int           cnt_bs, cnt_fe, cnt_ov, cnt_vcyc, cnt_vfall;
   logic [N-1:0] last_data;
   logic         prev_dv;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = 0;
      m_t     = 0;
      l1      = 1'b1;
      ls      = 1'b1;
      lq      = 1'b1;
      m_byte  = '0;
      m_data  = '0;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_over  = 1'b0;
   endtask

   // Advance over one rising edge, using the inputs seen during the cycle that ended.
   task automatic model_advance();
      logic done;
      logic err;
      int   k;
      done   = 1'b0;
      err    = 1'b0;
      m_ferr = 1'b0;
      m_over = 1'b0;
      case (m_mode)
         0: if (lq && !ls) begin
            m_mode = 1;
            m_t    = 1;
         end
         1: begin
            if (m_t == 8) begin
               if (ls) m_mode = 0;
            end else if (m_t > 8 && (m_t - 8) % BIT_T == 0) begin
               k = (m_t - 8) / BIT_T;
               if (k <= N) m_byte[k-1] = ls;
               else begin
                  done   = ls;
                  err    = !ls;
                  m_mode = ls ? 0 : 2;
               end
            end
            m_t++;
         end
         default: if (ls) m_mode = 0;
      endcase
      if (done && (!m_valid || p_rdy)) begin
         m_data  = m_byte;
         m_valid = 1'b1;
      end else if (done) begin
         m_over = 1'b1;
      end else if (m_valid && p_rdy) begin
         m_valid = 1'b0;
      end
      m_ferr = err;
      lq = ls;
      ls = l1;
      l1 = p_rx;
   endtask

   task automatic compare_cycle();
      if (reset) model_reset();
      else if (!p_rst) model_advance();
      chk("baud_start", 32'(baud_start), 32'(m_mode == 0 && lq && !ls));
      chk("data_valid", 32'(data_valid), 32'(m_valid));
      chk("data",       32'(data),       32'(m_data));
      chk("frame_err",  32'(frame_err),  32'(m_ferr));
      chk("overrun",    32'(overrun),    32'(m_over));
      if (baud_start) cnt_bs++;
      if (frame_err)  cnt_fe++;
      if (overrun)    cnt_ov++;
      if (data_valid) begin
         cnt_vcyc++;
         last_data = data;
      end
      if (prev_dv && !data_valid) cnt_vfall++;
      prev_dv = data_valid;
      p_rx  = rx;
      p_rdy = data_ready;
      p_rst = reset;
   endtask

   // Baud generator: first tick 8 clocks after baud_start, then every 16.
   task automatic baud_gen();
      if (baud_start) begin
         btimer    = 8;
         baud_tick = 1'b0;
      end else if (btimer > 0) begin
         btimer--;
         if (btimer == 0) begin
            baud_tick = 1'b1;
            btimer    = BIT_T;
         end else begin
            baud_tick = 1'b0;
         end
      end else begin
         baud_tick = 1'b0;
      end
   endtask

   task automatic step();
      @(negedge clock);
      compare_cycle();
      baud_gen();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send(input logic [7:0] b, input logic stop_ok, input logic rdy_pulse, input int ncyc);
      int k;
      for (int i = 0; i < ncyc; i++) begin
         k = i / BIT_T;
         if (k == 0)      rx = 1'b0;
         else if (k <= N) rx = b[k-1];
         else             rx = stop_ok;
         if (rdy_pulse) data_ready = (i == STOP_CYC);
         step();
      end
   endtask

   int bs0, fe0, ov0, vc0, vf0;

   task automatic snap();
      bs0 = cnt_bs;
      fe0 = cnt_fe;
      ov0 = cnt_ov;
      vc0 = cnt_vcyc;
      vf0 = cnt_vfall;
   endtask

   initial begin
      reset      = 1'b1;
      rx         = 1'b1;
      baud_tick  = 1'b0;
      data_ready = 1'b0;
      btimer     = 0;
      cnt_bs = 0; cnt_fe = 0; cnt_ov = 0; cnt_vcyc = 0; cnt_vfall = 0;
      last_data = '0;
      prev_dv   = 1'b0;
      p_rx = 1'b1; p_rdy = 1'b0; p_rst = 1'b1;
      model_reset();

      @(posedge clock);
      #1;
      chk("rst_data_valid", 32'(data_valid), 32'd0);
      chk("rst_data",       32'(data),       32'd0);
      chk("rst_baud_start", 32'(baud_start), 32'd0);
      idle(3);
      reset = 1'b0;
      idle(20);

      // Clean frame, consumer always ready.
      data_ready = 1'b1;
      snap();
      send(8'hA5, 1'b1, 1'b0, FRAME_T);
      idle(10);
      chk("a5_baud_starts", 32'(cnt_bs - bs0),   32'd1);
      chk("a5_valid_cycles", 32'(cnt_vcyc - vc0), 32'd1);
      chk("a5_data",        32'(last_data),      32'hA5);
      chk("a5_model_data",  32'(m_data),         32'hA5);
      chk("a5_flags",       32'(cnt_fe - fe0 + cnt_ov - ov0), 32'd0);

      // Two-clock glitch: false start, nothing reported.
      snap();
      rx = 1'b0;
      idle(2);
      rx = 1'b1;
      idle(40);
      chk("glitch_baud_starts", 32'(cnt_bs - bs0),   32'd1);
      chk("glitch_valid",       32'(cnt_vcyc - vc0), 32'd0);
      chk("glitch_ferr",        32'(cnt_fe - fe0),   32'd0);

      // Low stop bit, then recovery with a good frame.
      snap();
      send(8'h3C, 1'b0, 1'b0, FRAME_T);
      rx = 1'b1;
      idle(20);
      chk("ferr_pulses", 32'(cnt_fe - fe0),   32'd1);
      chk("ferr_valid",  32'(cnt_vcyc - vc0), 32'd0);
      send(8'h81, 1'b1, 1'b0, FRAME_T);
      idle(10);
      chk("post_ferr_data",  32'(last_data),      32'h81);
      chk("post_ferr_valid", 32'(cnt_vcyc - vc0), 32'd1);

      // Consumer stalled: second byte overruns, first is held.
      data_ready = 1'b0;
      snap();
      send(8'h11, 1'b1, 1'b0, FRAME_T);
      idle(4);
      send(8'h22, 1'b1, 1'b0, FRAME_T);
      idle(10);
      chk("ovr_pulses", 32'(cnt_ov - ov0), 32'd1);
      chk("ovr_data",   32'(data),         32'h11);
      chk("ovr_valid",  32'(data_valid),   32'd1);
      data_ready = 1'b1;
      step();
      data_ready = 1'b0;
      step();
      chk("ovr_accept_clears", 32'(data_valid), 32'd0);
      chk("ovr_model_data",    32'(m_data),     32'h11);

      // Ready on the exact completion cycle: pending byte consumed, new one loaded.
      send(8'h33, 1'b1, 1'b0, FRAME_T);
      idle(4);
      snap();
      send(8'h44, 1'b1, 1'b1, FRAME_T);
      data_ready = 1'b0;
      idle(10);
      chk("same_cyc_overrun", 32'(cnt_ov - ov0),    32'd0);
      chk("same_cyc_no_drop", 32'(cnt_vfall - vf0), 32'd0);
      chk("same_cyc_data",    32'(data),            32'h44);
      chk("same_cyc_valid",   32'(data_valid),      32'd1);

      // Reset during data bit 4 while a byte is still pending.
      send(8'h5A, 1'b1, 1'b0, 85);
      reset = 1'b1;
      rx    = 1'b1;
      #1;
      chk("midrst_valid", 32'(data_valid), 32'd0);
      chk("midrst_data",  32'(data),       32'd0);
      chk("midrst_pulses", 32'(baud_start | frame_err | overrun), 32'd0);
      idle(3);
      reset = 1'b0;
      snap();
      idle(200);
      chk("postrst_quiet", 32'(cnt_bs - bs0 + cnt_fe - fe0 + cnt_ov - ov0 + cnt_vcyc - vc0), 32'd0);
      data_ready = 1'b1;
      snap();
      send(8'h5A, 1'b1, 1'b0, FRAME_T);
      idle(10);
      chk("postrst_data",  32'(last_data),      32'h5A);
      chk("postrst_valid", 32'(cnt_vcyc - vc0), 32'd1);
      chk("postrst_bs",    32'(cnt_bs - bs0),   32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
